reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/reg_wb_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, the writeback request
// payload, and the writeback source selector used by the arbiter.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_PIPE,
    SEL_QUEUE
  } wb_sel_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending writeback requests.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (empties queue)
//   push, push_data   enqueue one request (ignored when full)
//   pop               dequeue the head (ignored when empty)
//   head              current head entry (valid when !empty)
//   full, empty       occupancy flags
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Merges the single-cycle pipeline writeback with a queue of long-latency
// writes onto one registered register-file write port. A starvation counter
// forces a one-cycle pipe_stall so queued writes cannot be denied forever.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pipe_we/pipe_wa/pipe_wd   pipeline writeback request (no handshake)
//   ll_valid/ll_wa/ll_wd      long-latency write request
//   ll_ready                  queue can accept a long-latency write
//   iss_valid/iss_wa          long-latency op issued; marks iss_wa pending
//   q_ra1/q_ra2, q_busy1/2    scoreboard queries (combinational)
//   rf_we/rf_wa/rf_wd         registered register-file write port
//   pipe_stall                registered; upstream holds writeback while high
module reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned LL_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_wa,
  input  logic [DATA_W-1:0]     pipe_wd,
  input  logic                  ll_valid,
  input  logic [REG_ADDR_W-1:0] ll_wa,
  input  logic [DATA_W-1:0]     ll_wd,
  output logic                  ll_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_wa,
  input  logic [REG_ADDR_W-1:0] q_ra1,
  input  logic [REG_ADDR_W-1:0] q_ra2,
  output logic                  q_busy1,
  output logic                  q_busy2,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0]     rf_wd,
  output logic                  pipe_stall
);

  localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
  localparam logic [NUM_REGS-1:0] BUSY_MASK = ~NUM_REGS'(1);

  wb_req_t             q_head;
  wb_req_t             q_in;
  logic                q_full;
  logic                q_empty;
  logic                q_push;
  logic                q_pop;
  wb_sel_t             sel;
  logic [SW-1:0]       starve_cnt;
  logic                starve_hit;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  // ll_ready depends only on stored occupancy (and reset), never on ll_valid.
  assign ll_ready = !rst && !q_full;
  assign q_push   = ll_valid && ll_ready && (ll_wa != '0);
  assign q_pop    = (sel == SEL_QUEUE);
  assign q_in     = '{wa: ll_wa, wd: ll_wd};

  wb_fifo #(
    .DEPTH(LL_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Stall cycle gives the queue head absolute priority and drops pipe_we.
  always_comb begin
    sel = SEL_NONE;
    if (pipe_stall && !q_empty) begin
      sel = SEL_QUEUE;
    end else if (pipe_we && !pipe_stall && (pipe_wa != '0)) begin
      sel = SEL_PIPE;
    end else if (!q_empty) begin
      sel = SEL_QUEUE;
    end
  end

  // The counter clears on the same edge that raises pipe_stall, so reaching
  // the limit and saturating collapse into a single compare on LIMIT-1.
  assign starve_hit = !q_empty && (sel == SEL_PIPE) && (starve_cnt == STARVE_LAST);

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_valid) begin
      busy_set[iss_wa] = 1'b1;
    end
    if (q_pop) begin
      busy_clr[q_head.wa] = 1'b1;
    end
  end

  assign q_busy1 = busy[q_ra1];
  assign q_busy2 = busy[q_ra2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= (sel != SEL_NONE);
      case (sel)
        SEL_PIPE: begin
          rf_wa <= pipe_wa;
          rf_wd <= pipe_wd;
        end
        SEL_QUEUE: begin
          rf_wa <= q_head.wa;
          rf_wd <= q_head.wd;
        end
        default: begin
          rf_wa <= rf_wa;
          rf_wd <= rf_wd;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      pipe_stall <= starve_hit;
      if ((sel == SEL_PIPE) && !q_empty && !starve_hit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~busy_clr) | busy_set) & BUSY_MASK;
    end
  end

endmodule
